seq_serializer: RTL
===================

# seq_serializer

Parallel-to-serial front end for the 10110 sequence detector: accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per enabled clock, MSB first, on a serial output. The serial output drives the detector's `in` input. A one-word holding register backs the shift register, so consecutive words stream with no idle cycle between them. A synchronous `clear` aborts any word in flight.

## Interface
- `WIDTH`, default 16: word width in bits, must be ≥ 2.
- `CNT_W`, default 4: bit-counter width, equal to ceil(log2(WIDTH)).
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort; discards the holding and shift registers.
- `load_data`, input, WIDTH: word to serialize.
- `load_valid`, input, 1: `load_data` is valid this cycle.
- `load_ready`, output, 1: the holding register is empty; a word can be accepted this cycle.
- `en`, input, 1: shift enable (downstream advance); the consumer samples `bit_out` only when `bit_valid && en`.
- `bit_out`, output, 1: current serial bit.
- `bit_valid`, output, 1: `bit_out` carries a word bit.
- `last_bit`, output, 1: `bit_valid` and the current bit is bit 0 of the word.
- `busy`, output, 1: the shifter or the holding register is occupied.

## Operation
- Storage:
  - `hold` (WIDTH) with flag `hold_full`.
  - `shreg` (WIDTH).
  - `cnt` (CNT_W), counting bits already presented.
  - FSM state: IDLE or SHIFT.
- Accept: a word is accepted when `load_valid && load_ready`. `load_ready = !hold_full`, with no combinational path from `load_valid`. On the accepting edge, `hold <= load_data` and `hold_full <= 1`.
- Transfer: `hold` moves to `shreg` on an edge where `hold_full` is set and one of these holds:
  - state is IDLE, or
  - state is SHIFT, `en` = 1 and `cnt` = WIDTH-1.
  
  On transfer, `cnt <= 0`, state <= SHIFT and `hold_full <= 0`. An accept on the same edge re-sets `hold_full`; the accept wins, because `load_ready` was already 1 that cycle.
- Shift: in SHIFT with `en` = 1 and `cnt` < WIDTH-1, `shreg` shifts left by one and `cnt` increments. With `en` = 0, `shreg` and `cnt` are frozen.
- Word end: in SHIFT with `en` = 1 and `cnt` = WIDTH-1:
  - if a transfer occurs, the state stays SHIFT;
  - otherwise the state goes to IDLE.
- Outputs:
  - `bit_out = shreg[WIDTH-1]` in SHIFT, 0 in IDLE.
  - `bit_valid` = (state == SHIFT).
  - `last_bit = bit_valid && cnt == WIDTH-1`.
  - `busy = bit_valid || hold_full`.
- Clear: on an edge with `clear` = 1:
  - state <= IDLE, `hold_full <= 0`, `cnt <= 0`, `shreg <= 0`.
  - Clear overrides accept, transfer and shift on the same edge; a `load_valid` present on that edge is dropped.
- Reset (`reset` = 0), asynchronously and mid-word included: state IDLE, `hold_full` 0, `cnt` 0, `shreg` 0.
  - Outputs during and after reset: `load_ready` = 1, `bit_out` = 0, `bit_valid` = 0, `last_bit` = 0, `busy` = 0.

## Timing
- Latency: a word accepted at edge E0 reaches `hold`. It transfers at E1, so its MSB is on `bit_out` with `bit_valid` = 1 in the cycle after E1.
- Throughput: one bit per `en` cycle. Back-to-back words give no `bit_valid` gap if the next word is in `hold` by the last-bit edge.
- A full word takes WIDTH enabled cycles. Stall cycles (`en` = 0) extend it one-for-one.
- `load_ready` re-asserts the cycle after a transfer, so at most two words are in the block at once.
- Handshake: the upstream holds `load_data` stable while `load_valid` = 1 and `load_ready` = 0. Dropping `load_valid` before acceptance is legal; nothing is captured.

## Test plan
- Reset then single word: after release, load 16'h5B36 with `en` = 1 throughout.
  - `bit_out` over 16 cycles = 0101101100110110.
  - `last_bit` only on the 16th bit; `bit_valid` falls the next cycle; `busy` = 0 after that.
- Back-to-back: hold `load_valid` = 1 with 16'hB0B0 then 16'hFFFF. Require:
  - 32 consecutive `bit_valid` cycles, no gap;
  - the second word's `load_ready` handshake completes during the first word's shift;
  - `load_ready` = 0 while the holding register is full.
- Stall: load 16'h8001 and drop `en` for 3 cycles after bit 5. Require `bit_out` and `cnt` frozen, `bit_valid` = 1 throughout, and `last_bit` asserted 3 cycles later than the unstalled case.
- Clear mid-word: at bit 7 of 16'h5B36, with a second word held, pulse `clear` together with `load_valid`. Require:
  - next cycle `bit_valid` = 0, `busy` = 0, `load_ready` = 1;
  - the concurrent word is not captured.
- Async reset mid-word: drive `reset` = 0 between edges. Require `bit_valid`, `bit_out`, `last_bit` and `busy` to go to 0 and `load_ready` to 1 immediately, without waiting for a clock edge.
- End-to-end: stream 16'h5B36 into the 10110 detector (`in` = `bit_out`, advanced on `bit_valid && en`). Require detector `out` = 1 exactly where the detector's own transitions flag 10110 in 0101101100110110.

Source files
------------

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per
// enabled cycle out (MSB first). A holding register lets words stream gap-free.
module seq_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             at_last;
  logic             xfer;

  always_comb begin
    accept      = load_valid && !hold_full_q;
    at_last     = (cnt_q == CNT_LAST);
    // The held word refills the shifter on the same edge the last bit leaves.
    xfer        = hold_full_q && ((state_q == IDLE) || (state_q == SHIFT && en && at_last));
    state_d     = state_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    if (clear) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      shreg_d     = '0;
      cnt_d       = '0;
    end else begin
      if (xfer) begin
        shreg_d     = hold_q;
        cnt_d       = '0;
        state_d     = SHIFT;
        hold_full_d = 1'b0;
      end else if (state_q == SHIFT && en) begin
        if (at_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      if (accept) begin
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
    end
  end

  // Holding data needs no reset; hold_full_q qualifies it.
  always_ff @(posedge clk) begin
    if (accept && !clear) begin
      hold_q <= load_data;
    end
  end

  assign load_ready = !hold_full_q;
  assign bit_valid  = (state_q == SHIFT);
  assign bit_out    = bit_valid && shreg_q[WIDTH-1];
  assign last_bit   = bit_valid && at_last;
  assign busy       = bit_valid || hold_full_q;

endmodule
